// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keying controller.
// Build option: MORSE_WORD_GAP_EN turns a zero-length ROM entry into a word gap.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MARK,
    SPACE,
`ifdef MORSE_WORD_GAP_EN
    CGAP,
    WGAP
`else
    CGAP
`endif
  } state_e;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 5;
  localparam int PAT_W   = 5;

  localparam logic [2:0] MAX_LEN = 3'(PAT_W);

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

endpackage

// File: rtl/morse_unit_timer.sv
// Counts a whole number of Morse units; expire is high in the last cycle.
// Build option: none (MORSE_WORD_GAP_EN only affects the controller).
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 5000000,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] units,
  output logic       expire
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       unit_q, unit_d;
  logic [2:0]       units_q, units_d;
  logic             last_cyc, last_unit;

  assign last_cyc  = (cyc_q == CNT_W'(UNIT_CYCLES - 1));
  assign last_unit = (unit_q == units_q - 3'd1);
  assign expire    = active_q && last_cyc && last_unit;

  always_comb begin
    active_d = active_q;
    cyc_d    = cyc_q;
    unit_d   = unit_q;
    units_d  = units_q;
    if (start) begin
      active_d = 1'b1;
      cyc_d    = '0;
      unit_d   = '0;
      units_d  = units;
    end else if (active_q) begin
      if (last_cyc) begin
        cyc_d = '0;
        if (last_unit) active_d = 1'b0;
        else           unit_d   = unit_q + 3'd1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cyc_q    <= '0;
      unit_q   <= '0;
      units_q  <= '0;
    end else begin
      active_q <= active_d;
      cyc_q    <= cyc_d;
      unit_q   <= unit_d;
      units_q  <= units_d;
    end
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse keying controller: ROM lookup per character, then marks and gaps.
// Build option: MORSE_WORD_GAP_EN plays a zero-length entry as a 7-unit word gap.
module morse_tx_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5000000,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_data,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tone,
  output logic       busy,
  output logic       done
);

  state_e           state_q, state_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic [2:0]       len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;

  logic [2:0]       len_raw, len_clamp;
  logic [PAT_W-1:0] pat_align;
  logic             t_start, t_expire;
  logic [2:0]       t_units;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (t_start),
    .units (t_units),
    .expire(t_expire)
  );

  // Left-align the pattern so the next symbol is always the MSB.
  always_comb begin
    len_raw   = rom_data[LEN_MSB:LEN_LSB];
    len_clamp = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    pat_align = rom_data[PAT_W-1:0] << (MAX_LEN - len_clamp);
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    len_d      = len_q;
    pat_d      = pat_q;
    done_d     = 1'b0;
    t_start    = 1'b0;
    t_units    = DOT_UNITS;
    unique case (state_q)
      IDLE: begin
        if (char_valid) begin
          rom_addr_d = char_data;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (len_clamp == 3'd0) begin
`ifdef MORSE_WORD_GAP_EN
          state_d = WGAP;
          t_start = 1'b1;
          t_units = WORD_GAP_UNITS;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          len_d   = len_clamp;
          pat_d   = pat_align;
          state_d = MARK;
          t_start = 1'b1;
          t_units = pat_align[PAT_W-1] ? DASH_UNITS : DOT_UNITS;
        end
      end
      MARK: begin
        if (t_expire) begin
          pat_d   = pat_q << 1;
          len_d   = len_q - 3'd1;
          t_start = 1'b1;
          if (len_q > 3'd1) begin
            state_d = SPACE;
            t_units = SYM_GAP_UNITS;
          end else begin
            state_d = CGAP;
            t_units = CHAR_GAP_UNITS;
          end
        end
      end
      SPACE: begin
        if (t_expire) begin
          state_d = MARK;
          t_start = 1'b1;
          t_units = pat_q[PAT_W-1] ? DASH_UNITS : DOT_UNITS;
        end
      end
      CGAP: begin
        if (t_expire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      WGAP: begin
        if (t_expire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    tone_d = (state_d == MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rom_addr   = rom_addr_q;
  assign tone       = tone_q;
  assign done       = done_q;

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Directed bench for morse_tx_ctrl with UNIT_CYCLES=4 and a small ROM model.
// Build option: MORSE_WORD_GAP_EN changes the expected zero-length result.
module tb_morse_tx_ctrl;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [7:0] rom_data = 8'h00;
  logic       char_ready;
  logic [7:0] rom_addr;
  logic       tone;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  morse_tx_ctrl #(
    .UNIT_CYCLES(U),
    .CNT_W      (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_data (char_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tone      (tone),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_lut(input logic [7:0] a);
    case (a)
      8'h45:   return 8'h20;
      8'h41:   return 8'h41;
      8'h20:   return 8'h00;
      8'h5A:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_lut(rom_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || tone !== 1'b0 ||
          char_ready !== 1'b1)
        e++;
    end
    chk("idle_quiet", e, 0);
  endtask

  // Offer code at the current negedge and follow it cycle by cycle.
  task automatic run_char(input logic [7:0] code, input int n_sym,
                          input logic [4:0] dash, input int done_at,
                          input bit hold, input bit chain);
    logic exp_tone [0:127];
    int t, hi;
    int e_tone = 0, e_done = 0, e_busy = 0, e_addr = 0;
    for (int i = 0; i < 128; i++) exp_tone[i] = 1'b0;
    t = 3;
    for (int s = n_sym - 1; s >= 0; s--) begin
      hi = dash[s] ? 3 * U : U;
      for (int k = 0; k < hi; k++) exp_tone[t + k] = 1'b1;
      t += hi;
      t += (s == 0) ? 3 * U : U;
    end
    chk("ready_at_offer", char_ready, 1);
    char_valid = 1'b1;
    char_data  = code;
    for (int c = 1; c <= done_at; c++) begin
      @(negedge clk);
      if (tone !== exp_tone[c]) e_tone++;
      if (done !== (c == done_at)) e_done++;
      if (busy !== (c < done_at)) e_busy++;
      if (c < done_at && rom_addr !== code) e_addr++;
      if (c < done_at) begin
        if (hold) char_data = ~code;
        else      char_valid = 1'b0;
      end
    end
    chk("tone_trace", e_tone, 0);
    chk("done_pulse", e_done, 0);
    chk("busy_window", e_busy, 0);
    chk("rom_addr_hold", e_addr, 0);
    chk("ready_at_done", char_ready, 1);
    if (!chain) char_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] code;
    int         n_sym;
    logic [4:0] dash;
    int         done_at;
    bit         hold;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{code: 8'h45, n_sym: 1, dash: 5'b00000, done_at: 19, hold: 1'b0};
    vecs[1] = '{code: 8'h41, n_sym: 2, dash: 5'b00001, done_at: 35, hold: 1'b1};
`ifdef MORSE_WORD_GAP_EN
    vecs[2] = '{code: 8'h20, n_sym: 0, dash: 5'b00000, done_at: 31, hold: 1'b1};
`else
    vecs[2] = '{code: 8'h20, n_sym: 0, dash: 5'b00000, done_at: 3, hold: 1'b1};
`endif
    vecs[3] = '{code: 8'h5A, n_sym: 5, dash: 5'b11111, done_at: 91, hold: 1'b0};

    #1;
    chk("rst_tone", tone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ready", char_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      run_char(vecs[i].code, vecs[i].n_sym, vecs[i].dash,
               vecs[i].done_at, vecs[i].hold, 1'b0);
      idle(2);
    end

    // Back-to-back: second character accepted in the done cycle.
    run_char(8'h45, 1, 5'b00000, 19, 1'b0, 1'b1);
    run_char(8'h41, 2, 5'b00001, 35, 1'b0, 1'b0);
    idle(2);

    // Reset in the middle of the first dash.
    char_valid = 1'b1;
    char_data  = 8'h5A;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("tone_before_reset", tone, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tone", tone, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", rom_addr, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", char_ready, 1);
    idle(20);
    run_char(8'h45, 1, 5'b00000, 19, 1'b0, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
